// File: rtl/sp_rx_aligner.sv
// rtl/sp_rx_aligner.sv - serial-to-parallel receiver with comma hunt, word lock and link-active detection
//
// Purpose:
//   Deserialises an MSB-first bit stream, hunts COMMA at any bit offset,
//   locks the word boundary and declares the link active after SYNC_COUNT
//   consecutive aligned commas. While active, non-comma words are delivered
//   on data_out with a one-cycle valid_out strobe.
//
// Optional feature macro: RX_LOSS_DET_EN
//   When defined, the link drops back to SEARCH after LOSS_WORDS word
//   boundaries without an aligned comma. When undefined, LOSS_WORDS is unused
//   and ACTIVE is left only by reset.
//
// Ports:
//   clk_32f    in   1      bit clock, all logic on posedge
//   reset      in   1      synchronous, active-high
//   data_in    in   1      serial data, MSB first
//   data_out   out  WIDTH  last delivered data word
//   valid_out  out  1      one-cycle strobe when data_out takes a non-comma word
//   active     out  1      link locked
module sp_rx_aligner #(
    parameter int                 WIDTH      = 8,
    parameter logic [WIDTH-1:0]   COMMA      = WIDTH'(8'hBC),
    parameter int                 SYNC_COUNT = 4,
    parameter int                 LOSS_WORDS = 16
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active
);

    localparam int BW = $clog2(WIDTH);
    localparam int CW = $clog2(SYNC_COUNT + 1);

    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_COUNT - 1);
    localparam logic [CW-1:0] SYNC_FULL = CW'(SYNC_COUNT);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] SYNC   = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;

    // Reject illegal parameterisations at elaboration time.
    if (WIDTH < 2 || SYNC_COUNT < 1 || LOSS_WORDS < 1) begin : g_param_check
        $error("sp_rx_aligner: illegal parameter value");
    end

    logic [1:0]       state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] nxt;
    logic [BW-1:0]    bit_cnt;
    logic [CW-1:0]    comma_cnt;
    logic             boundary;

`ifdef RX_LOSS_DET_EN
    localparam int GW = $clog2(LOSS_WORDS + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(LOSS_WORDS - 1);
    logic [GW-1:0] gap_cnt;
`endif

    // Window including the bit arriving this cycle; all decisions use it so
    // the word is recognised at the same edge its last bit is sampled.
    assign nxt      = {sr[WIDTH-2:0], data_in};
    assign boundary = (bit_cnt == LAST_BIT);

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state     <= SEARCH;
            sr        <= '0;
            bit_cnt   <= '0;
            comma_cnt <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
`ifdef RX_LOSS_DET_EN
            gap_cnt   <= '0;
`endif
        end else begin
            sr        <= nxt;
            valid_out <= 1'b0;

            // Word counter only runs once a boundary has been chosen.
            if (state != SEARCH) begin
                bit_cnt <= boundary ? '0 : bit_cnt + 1'b1;
            end

            case (state)
                SEARCH: begin
`ifdef RX_LOSS_DET_EN
                    gap_cnt <= '0;
`endif
                    if (nxt == COMMA) begin
                        bit_cnt   <= '0;
                        comma_cnt <= CW'(1);
                        if (SYNC_COUNT == 1) begin
                            state  <= ACTIVE;
                            active <= 1'b1;
                        end else begin
                            state <= SYNC;
                        end
                    end
                end

                SYNC: begin
`ifdef RX_LOSS_DET_EN
                    gap_cnt <= '0;
`endif
                    if (boundary) begin
                        if (nxt == COMMA) begin
                            // Counter stops at SYNC_COUNT, so it cannot wrap.
                            if (comma_cnt >= SYNC_LAST) begin
                                comma_cnt <= SYNC_FULL;
                                state     <= ACTIVE;
                                active    <= 1'b1;
                            end else begin
                                comma_cnt <= comma_cnt + 1'b1;
                            end
                        end else begin
                            // Misaligned guess: restart the bit hunt from the next bit.
                            comma_cnt <= '0;
                            state     <= SEARCH;
                        end
                    end
                end

                ACTIVE: begin
                    if (boundary) begin
`ifdef RX_LOSS_DET_EN
                        if (nxt == COMMA) begin
                            gap_cnt <= '0;
                        end else if (gap_cnt >= GAP_LAST) begin
                            // Too long without an idle: drop lock, do not deliver this word.
                            active    <= 1'b0;
                            state     <= SEARCH;
                            comma_cnt <= '0;
                            gap_cnt   <= '0;
                        end else begin
                            gap_cnt   <= gap_cnt + 1'b1;
                            data_out  <= nxt;
                            valid_out <= 1'b1;
                        end
`else
                        if (nxt != COMMA) begin
                            data_out  <= nxt;
                            valid_out <= 1'b1;
                        end
`endif
                    end
                end

                default: state <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_sp_rx_aligner.sv
// tb/tb_sp_rx_aligner.sv - directed self-checking bench for sp_rx_aligner
module tb_sp_rx_aligner;

    logic       clk;
    logic       reset;
    logic       din;
    logic [7:0] dout;
    logic       vout;
    logic       act;
    logic       din10;
    logic [9:0] dout10;
    logic       vout10;
    logic       act10;

    int n_cmp;
    int n_fail;

    sp_rx_aligner #(
        .WIDTH(8), .COMMA(8'hBC), .SYNC_COUNT(4), .LOSS_WORDS(4)
    ) dut (
        .clk_32f(clk), .reset(reset), .data_in(din),
        .data_out(dout), .valid_out(vout), .active(act)
    );

    sp_rx_aligner #(
        .WIDTH(10), .COMMA(10'h17C), .SYNC_COUNT(2), .LOSS_WORDS(16)
    ) dut10 (
        .clk_32f(clk), .reset(reset), .data_in(din10),
        .data_out(dout10), .valid_out(vout10), .active(act10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift one 8-bit word MSB first. valid must stay low on the first 7 bits;
    // on the last bit valid/active must match, and data must equal w when valid.
    task automatic send_word(input logic [7:0] w, input logic exp_v, input logic exp_act, input string nm);
        for (int i = 7; i >= 0; i--) begin
            din = w[i];
            @(posedge clk);
            #1;
            if (i > 0) begin
                n_cmp++;
                if (vout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s bit%0d valid_out got %b want 0", nm, i, vout);
                end
            end else begin
                n_cmp++;
                if (vout !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s valid_out got %b want %b", nm, vout, exp_v);
                end
                n_cmp++;
                if (act !== exp_act) begin
                    n_fail++;
                    $display("FAIL %s active got %b want %b", nm, act, exp_act);
                end
                if (exp_v) begin
                    n_cmp++;
                    if (dout !== w) begin
                        n_fail++;
                        $display("FAIL %s data_out got %h want %h", nm, dout, w);
                    end
                end
            end
        end
    endtask

    task automatic send_word10(input logic [9:0] w, input logic exp_v, input logic exp_act, input string nm);
        for (int i = 9; i >= 0; i--) begin
            din10 = w[i];
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (vout10 !== exp_v) begin
            n_fail++;
            $display("FAIL %s valid_out got %b want %b", nm, vout10, exp_v);
        end
        n_cmp++;
        if (act10 !== exp_act) begin
            n_fail++;
            $display("FAIL %s active got %b want %b", nm, act10, exp_act);
        end
        if (exp_v) begin
            n_cmp++;
            if (dout10 !== w) begin
                n_fail++;
                $display("FAIL %s data_out got %h want %h", nm, dout10, w);
            end
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        din   = 1'b1;
        din10 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({act, vout, dout} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset8 act/valid/data got %b/%b/%h want 0/0/00", act, vout, dout);
        end
        n_cmp++;
        if ({act10, vout10, dout10} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset10 act/valid/data got %b/%b/%h want 0/0/000", act10, vout10, dout10);
        end
        reset = 1'b0;
        din   = 1'b0;
    endtask

    task automatic test_lock_and_deliver();
        logic [6:0] junk;
        junk = 7'b1110010;
        for (int i = 6; i >= 0; i--) begin
            din = junk[i];
            @(posedge clk);
            #1;
            n_cmp++;
            if (vout !== 1'b0 || act !== 1'b0) begin
                n_fail++;
                $display("FAIL t1_junk valid/active got %b/%b want 0/0", vout, act);
            end
        end
        send_word(8'hF2, 1'b0, 1'b0, "t1_F2");
        send_word(8'h15, 1'b0, 1'b0, "t1_15");
        send_word(8'hBC, 1'b0, 1'b0, "t1_bc1");
        send_word(8'hBC, 1'b0, 1'b0, "t1_bc2");
        send_word(8'hBC, 1'b0, 1'b0, "t1_bc3");
        send_word(8'hBC, 1'b0, 1'b1, "t1_bc4");
        send_word(8'hDD, 1'b1, 1'b1, "t1_DD");
        send_word(8'h45, 1'b1, 1'b1, "t1_45");
        send_word(8'hAA, 1'b1, 1'b1, "t1_AA");
    endtask

    task automatic test_back_to_back();
        send_word(8'hBC, 1'b0, 1'b1, "t2_bc_a");
        send_word(8'h13, 1'b1, 1'b1, "t2_13");
        send_word(8'hBC, 1'b0, 1'b1, "t2_bc_b");
        n_cmp++;
        if (dout !== 8'h13) begin
            n_fail++;
            $display("FAIL t2_hold data_out got %h want 13", dout);
        end
        send_word(8'hDD, 1'b1, 1'b1, "t2_DD");
    endtask

    task automatic test_sync_abort();
        pulse_reset();
        send_word(8'hBC, 1'b0, 1'b0, "t3_bc1");
        send_word(8'hBC, 1'b0, 1'b0, "t3_bc2");
        send_word(8'h55, 1'b0, 1'b0, "t3_55");
        send_word(8'hBC, 1'b0, 1'b0, "t3_rbc1");
        send_word(8'hBC, 1'b0, 1'b0, "t3_rbc2");
        send_word(8'hBC, 1'b0, 1'b0, "t3_rbc3");
        send_word(8'hBC, 1'b0, 1'b1, "t3_rbc4");
        send_word(8'hDD, 1'b1, 1'b1, "t3_DD");
    endtask

    task automatic test_mid_word_reset();
        logic [7:0] part;
        part = 8'h5A;
        for (int i = 7; i >= 5; i--) begin
            din = part[i];
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_cmp++;
        if ({act, vout, dout} !== 10'd0) begin
            n_fail++;
            $display("FAIL t4_reset act/valid/data got %b/%b/%h want 0/0/00", act, vout, dout);
        end
        send_word(8'hBC, 1'b0, 1'b0, "t4_bc1");
        send_word(8'hBC, 1'b0, 1'b0, "t4_bc2");
        send_word(8'hBC, 1'b0, 1'b0, "t4_bc3");
        send_word(8'hBC, 1'b0, 1'b1, "t4_bc4");
    endtask

    task automatic test_loss_detect();
        send_word(8'h00, 1'b1, 1'b1, "t6_w1");
        send_word(8'h00, 1'b1, 1'b1, "t6_w2");
        send_word(8'h00, 1'b1, 1'b1, "t6_w3");
`ifdef RX_LOSS_DET_EN
        send_word(8'h00, 1'b0, 1'b0, "t6_w4");
`else
        send_word(8'h00, 1'b1, 1'b1, "t6_w4");
`endif
    endtask

    task automatic test_width10();
        pulse_reset();
        send_word10(10'h17C, 1'b0, 1'b0, "t5_c1");
        send_word10(10'h17C, 1'b0, 1'b1, "t5_c2");
        send_word10(10'h3FF, 1'b1, 1'b1, "t5_3FF");
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_lock_and_deliver();
        test_back_to_back();
        test_sync_abort();
        test_mid_word_reset();
        test_loss_detect();
        test_width10();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
